retospect_neurochip: RTL and testbench
======================================

Name: retospect_neurochip

Overview:
- Small field-programmable neural array for a TinyTapeout tile: 10 leaky integrate-and-fire neurons, each fed by a configurable subset of 10 dendrite inputs.
- Per-neuron synapse mask, threshold and leak are loaded through a 160-bit serial configuration chain (bitstream in/out).
- Top-level user module, attached directly to the standard tile pins.

Parameters:
- N_NEURONS, 10, number of neurons and number of dendrite inputs; fixed.
- CFG_BITS, 16, configuration bits per neuron; chain length N_NEURONS*CFG_BITS = 160.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset, clears all state including configuration
- ena  input  1  tile enable; when 0, neuron state holds (config chain still shifts)
- ui_in  input  8  dendrite[9:2]
- uo_out  output  8  spike outputs of neurons 9..2 (uo_out[7] = neuron 9)
- uio_in  input  8  [0] reset_nn, [2] bs_in, [3] config_en, [7:6] dendrite[1:0]; others unused
- uio_out  output  8  [1] bs_out, [5] neuron 1 spike, [4] neuron 0 spike; all other bits 0
- uio_oe  output  8  constant 8'b0011_0010

Behaviour:
- Dendrite vector d[9:0] = {ui_in[7:0], uio_in[7:6]}; out[9:0] = {uo_out[7:0], uio_out[5:4]}. All outputs are registered.
- Config chain, 160 flops c[159:0]:
  - On each clk with config_en=1: c <= {c[158:0], bs_in}.
  - bs_out = c[159]; a bit entering at cycle t appears on bs_out after 160 shifts.
- Neuron n field c[16n+15:16n]:
  - mask[9:0] = bits 9:0
  - thr[3:0] = bits 13:10
  - leak[1:0] = bits 15:14
- Per neuron: 4-bit accumulator acc and registered spike s.
- Each clk with ena=1, config_en=0, reset_nn=1:
  - sum = acc + popcount(d & mask), 5 bits.
  - If thr != 0 and sum >= thr: s <= 1, acc <= 0.
  - Else: s <= 0; acc <= (sum > leak) ? sum - leak : 0. Saturate acc at 15.
  - thr = 0 disables the neuron: s always 0 and acc integrates as above.
- Spike latency: d sampled at edge k gives s at edge k (visible after edge k); one-cycle pulse.
- config_en=1: all acc and s are synchronously cleared to 0 every cycle; chain shifts.
- reset_nn=0 (uio_in[0]): synchronously clears all acc and s; config retained; takes priority over integration; config shifting is still allowed.
- ena=0 with config_en=0: acc and s hold their values.
- rst_n=0 (asynchronous): c, acc and s all cleared to 0.
  - Reset values: uo_out = 0, uio_out = 0, uio_oe = 0x32.
  - Reset mid-shift discards the partial configuration.
- Unused inputs uio_in[1], uio_in[5:4] are ignored.

Test Plan:
- Assert rst_n=0 with arbitrary inputs -> uo_out=0x00, uio_out=0x00, uio_oe=0x32; after release with d=0x3FF and all-zero config, no spikes.
- Config loopback: config_en=1, shift a 160-bit pattern of alternating 1,0 followed by 160 zeros -> bs_out reproduces the pattern starting exactly 160 clocks after its first bit.
- Neuron 0 with mask=0x001, thr=1, leak=0; drive uio_in[6]=1 for one cycle -> uio_out[4]=1 for exactly one cycle; all other outputs stay 0.
- Neuron 9 with mask=0x200, thr=3, leak=0; hold ui_in[7]=1 -> uo_out[7] pulses every 3rd cycle (period 3).
- Leak: neuron 2 with mask=0x3FF, thr=15, leak=3; d = 2 active bits constant -> acc never reaches 15 and no spike ever. With d=0x3FF -> spike on the 2nd cycle (10, then 10-3+10=17 >= 15).
- Pulse reset_nn=0 for one cycle mid-integration -> acc cleared (spike period restarts) and configuration unchanged: bs_out still replays the stored chain on reshift.

Source files
------------

// File: rtl/retospect_neurochip.sv
// rtl/retospect_neurochip.sv - ten-neuron leaky integrate-and-fire array with serial config chain
//
// Ports:
//   clk      system clock, all state on the rising edge
//   rst_n    asynchronous active-low reset; clears config chain and neuron state
//   ena      tile enable; neuron state holds when low (config chain still shifts)
//   ui_in    dendrite[9:2]
//   uo_out   spikes of neurons 9..2 (uo_out[7] = neuron 9)
//   uio_in   [0] reset_nn, [2] bs_in, [3] config_en, [7:6] dendrite[1:0]
//   uio_out  [1] bs_out, [5] neuron 1 spike, [4] neuron 0 spike, others 0
//   uio_oe   constant 8'b0011_0010
module retospect_neurochip #(
    parameter int N_NEURONS = 10,
    parameter int CFG_BITS  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CHAIN_LEN = N_NEURONS * CFG_BITS;

    logic                 reset_nn;
    logic                 bs_in;
    logic                 config_en;
    logic [9:0]           dendrite;
    logic [CHAIN_LEN-1:0] chain;
    logic [N_NEURONS-1:0] spike;
    logic                 unused_inputs;

    assign reset_nn  = uio_in[0];
    assign bs_in     = uio_in[2];
    assign config_en = uio_in[3];
    assign dendrite  = {ui_in, uio_in[7:6]};

    assign unused_inputs = &{1'b0, uio_in[1], uio_in[5:4]};

    function automatic logic [3:0] popcount10(input logic [9:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 10; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

    // Configuration shift register; the first bit shifted in ends up at the top
    // (neuron 9, leak msb) once the whole chain has been loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else if (config_en) begin
            chain <= {chain[CHAIN_LEN-2:0], bs_in};
        end
    end

    for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
        logic [9:0] mask;
        logic [3:0] thr;
        logic [1:0] leak;
        logic [3:0] acc;
        logic       spike_q;
        logic [4:0] sum;
        logic [4:0] leaked;
        logic [3:0] acc_next;
        logic       fire;

        assign mask = chain[n*CFG_BITS +: 10];
        assign thr  = chain[n*CFG_BITS + 10 +: 4];
        assign leak = chain[n*CFG_BITS + 14 +: 2];

        assign sum    = {1'b0, acc} + {1'b0, popcount10(dendrite & mask)};
        // thr of zero disables firing but still lets the accumulator integrate.
        assign fire   = (thr != 4'd0) && (sum >= {1'b0, thr});
        assign leaked = (sum > {3'b000, leak}) ? (sum - {3'b000, leak}) : 5'd0;
        assign acc_next = (leaked > 5'd15) ? 4'd15 : leaked[3:0];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc     <= 4'd0;
                spike_q <= 1'b0;
            end else if (config_en || !reset_nn) begin
                acc     <= 4'd0;
                spike_q <= 1'b0;
            end else if (ena) begin
                if (fire) begin
                    acc     <= 4'd0;
                    spike_q <= 1'b1;
                end else begin
                    acc     <= acc_next;
                    spike_q <= 1'b0;
                end
            end
        end

        assign spike[n] = spike_q;
    end

    assign uo_out  = spike[9:2];
    assign uio_out = {2'b00, spike[1], spike[0], 2'b00, chain[CHAIN_LEN-1], 1'b0};
    assign uio_oe  = 8'b0011_0010;

endmodule

// File: tb/tb_retospect_neurochip.sv
// tb/tb_retospect_neurochip.sv - scoreboard bench for the neuron array
module tb_retospect_neurochip;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int vectors = 0;
    int miscompares = 0;

    logic [159:0] m_cfg;
    int           m_acc [10];
    logic [9:0]   m_s;
    logic [15:0]  exp_q [$];

    retospect_neurochip dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cfg = '0;
        m_s   = '0;
        for (int n = 0; n < 10; n++) m_acc[n] = 0;
    endtask

    task automatic model_clock();
        logic [9:0] d;
        int cnt, thr, leak, sum, nxt;
        d = {ui_in, uio_in[7:6]};
        if (uio_in[3]) begin
            m_cfg = {m_cfg[158:0], uio_in[2]};
            m_s   = '0;
            for (int n = 0; n < 10; n++) m_acc[n] = 0;
        end else if (!uio_in[0]) begin
            m_s = '0;
            for (int n = 0; n < 10; n++) m_acc[n] = 0;
        end else if (ena) begin
            for (int n = 0; n < 10; n++) begin
                cnt = 0;
                for (int j = 0; j < 10; j++)
                    if (d[j] && m_cfg[16*n+j]) cnt++;
                thr  = int'(m_cfg[16*n+10 +: 4]);
                leak = int'(m_cfg[16*n+14 +: 2]);
                sum  = m_acc[n] + cnt;
                if (thr != 0 && sum >= thr) begin
                    m_s[n]   = 1'b1;
                    m_acc[n] = 0;
                end else begin
                    m_s[n] = 1'b0;
                    nxt = sum - leak;
                    if (nxt < 0) nxt = 0;
                    if (nxt > 15) nxt = 15;
                    m_acc[n] = nxt;
                end
            end
        end
    endtask

    // One clock: predict, push, clock, pop and compare.
    task automatic step();
        logic [15:0] e;
        uio_in[1]   = 1'($urandom);
        uio_in[5:4] = 2'($urandom);
        model_clock();
        exp_q.push_back({m_s[9:2], 2'b00, m_s[1:0], 2'b00, m_cfg[159], 1'b0});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("uo_out", 32'(uo_out), 32'(e[15:8]));
        check("uio_out", 32'(uio_out), 32'(e[7:0]));
    endtask

    task automatic load_cfg(input logic [159:0] cfg);
        uio_in[3] = 1'b1;
        for (int i = 159; i >= 0; i--) begin
            uio_in[2] = cfg[i];
            step();
        end
        uio_in[3] = 1'b0;
        uio_in[2] = 1'b0;
    endtask

    function automatic logic [15:0] fld(input logic [1:0] leak, input logic [3:0] thr,
                                        input logic [9:0] mask);
        return {leak, thr, mask};
    endfunction

    initial begin
        logic [159:0] cfg;
        int cnt;

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'hA5;
        uio_in = 8'h5B;
        model_reset();
        #12;
        check("rst_uo_out", 32'(uo_out), 32'h00);
        check("rst_uio_out", 32'(uio_out), 32'h00);
        check("rst_uio_oe", 32'(uio_oe), 32'h32);
        rst_n  = 1'b1;
        uio_in = 8'hC1;
        ui_in  = 8'hFF;
        for (int i = 0; i < 5; i++) step();

        // Config loopback: alternating pattern then zeros.
        ui_in  = 8'h00;
        uio_in = 8'h09;
        cnt = 0;
        for (int i = 0; i < 160; i++) begin
            uio_in[2] = (i % 2 == 0);
            step();
            if (i == 158) check("loop_before", 32'(uio_out[1]), 32'd0);
            if (i == 159) check("loop_first", 32'(uio_out[1]), 32'd1);
        end
        uio_in[2] = 1'b0;
        for (int i = 0; i < 160; i++) begin
            step();
            if (uio_out[1]) cnt++;
        end
        check("loop_ones", 32'(cnt), 32'd79);
        uio_in[3] = 1'b0;

        // Neuron 0 single pulse.
        cfg = '0;
        cfg[15:0] = fld(2'd0, 4'd1, 10'h001);
        load_cfg(cfg);
        uio_in[6] = 1'b1;
        step();
        check("n0_spike", 32'(uio_out[4]), 32'd1);
        uio_in[6] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (uio_out[4]) cnt++;
        end
        check("n0_one_cycle", 32'(cnt), 32'd0);

        // Neuron 9 period 3.
        cfg = '0;
        cfg[159:144] = fld(2'd0, 4'd3, 10'h200);
        load_cfg(cfg);
        ui_in[7] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (uo_out[7]) cnt++;
            if (i == 2) check("n9_third", 32'(uo_out[7]), 32'd1);
        end
        check("n9_count", 32'(cnt), 32'd3);

        // Enable low holds state.
        ui_in[7] = 1'b1;
        step();
        ena = 1'b0;
        for (int i = 0; i < 3; i++) step();
        ena = 1'b1;
        step();
        step();
        check("ena_resume", 32'(uo_out[7]), 32'd1);

        // reset_nn mid-integration restarts the period.
        step();
        step();
        uio_in[0] = 1'b0;
        step();
        uio_in[0] = 1'b1;
        step();
        step();
        check("rnn_no_early", 32'(uo_out[7]), 32'd0);
        step();
        check("rnn_restart", 32'(uo_out[7]), 32'd1);
        ui_in = 8'h00;
        // Reshift with zeros: bs_out replays the stored chain.
        uio_in[3] = 1'b1;
        uio_in[2] = 1'b0;
        for (int i = 0; i < 160; i++) step();
        uio_in[3] = 1'b0;

        // Leak: neuron 2.
        cfg = '0;
        cfg[47:32] = fld(2'd3, 4'd15, 10'h3FF);
        load_cfg(cfg);
        uio_in[7:6] = 2'b11;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (uo_out[0]) cnt++;
        end
        check("leak_never", 32'(cnt), 32'd0);
        ui_in = 8'hFF;
        step();
        check("leak_first", 32'(uo_out[0]), 32'd0);
        step();
        check("leak_second", 32'(uo_out[0]), 32'd1);
        for (int i = 0; i < 6; i++) step();

        // Asynchronous reset mid-shift discards the partial configuration.
        uio_in[3] = 1'b1;
        uio_in[2] = 1'b1;
        for (int i = 0; i < 20; i++) step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_uio", 32'(uio_out), 32'h00);
        check("mid_rst_uo", 32'(uo_out), 32'h00);
        rst_n = 1'b1;
        uio_in[2] = 1'b0;
        for (int i = 0; i < 160; i++) step();
        uio_in[3] = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
